// File: rtl/addr_compress_unit.sv
// Registered address compressor: folds an AW_IN-bit address into an AW_OUT-bit local space
// using a runtime-selected mapping, with out-of-range flagging and a saturating OOR counter.
module addr_compress_unit #(
    parameter int AW_IN  = 8,
    parameter int AW_OUT = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [AW_IN-1:0]  cfg_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW_IN-1:0]  in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW_OUT-1:0] out_addr,
    output logic              out_oor,
    input  logic              oor_clr,
    output logic [CNT_W-1:0]  oor_count
);

    localparam int NCHUNK = (AW_IN + AW_OUT - 1) / AW_OUT;

    typedef enum logic [1:0] {
        M_TRUNC  = 2'd0,
        M_CHECK  = 2'd1,
        M_OFFSET = 2'd2,
        M_FOLD   = 2'd3
    } mode_t;

    mode_t               mode_q;
    logic [AW_IN-1:0]    base_q;
    logic [AW_OUT:0]     map_p0;
    logic                in_xfer;
    logic                out_xfer;

    function automatic logic [AW_OUT-1:0] fold(input logic [AW_IN-1:0] a);
        logic [NCHUNK*AW_OUT-1:0] padded;
        logic [AW_OUT-1:0]        acc;
        padded           = '0;
        padded[AW_IN-1:0] = a;
        acc              = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            acc = acc ^ padded[i*AW_OUT +: AW_OUT];
        end
        return acc;
    endfunction

    // Returns {oor, addr}; in OFFSET mode the extra MSB of the difference is the borrow.
    function automatic logic [AW_OUT:0] map_addr(input mode_t m, input logic [AW_IN-1:0] b,
                                                 input logic [AW_IN-1:0] a);
        logic [AW_IN:0] diff;
        logic [AW_OUT:0] res;
        diff = {1'b0, a} - {1'b0, b};
        case (m)
            M_TRUNC:  res = {1'b0, a[AW_OUT-1:0]};
            M_CHECK:  res = {|a[AW_IN-1:AW_OUT], a[AW_OUT-1:0]};
            M_OFFSET: res = {diff[AW_IN] | (|diff[AW_IN-1:AW_OUT]), diff[AW_OUT-1:0]};
            default:  res = {1'b0, fold(a)};
        endcase
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        map_p0 = map_addr(mode_q, base_q, in_addr);
    end

    // Config takes effect for beats accepted after the write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_TRUNC;
            base_q <= '0;
        end else if (cfg_we) begin
            mode_q <= mode_t'(cfg_mode);
            base_q <= cfg_base;
        end
    end

    // Output register stage: EMPTY when out_valid=0, FULL when out_valid=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_oor   <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_addr  <= map_p0[AW_OUT-1:0];
            out_oor   <= map_p0[AW_OUT];
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oor_count <= '0;
        end else if (oor_clr) begin
            oor_count <= '0;
        end else if (out_xfer && out_oor) begin
            oor_count <= sat_inc(oor_count);
        end
    end

endmodule

// File: tb/tb_addr_compress_unit.sv
// Scoreboard bench for addr_compress_unit: directed cases plus a randomized stream with
// random backpressure, checked against an integer-arithmetic reference model.
module tb_addr_compress_unit;

    localparam int AW_IN  = 8;
    localparam int AW_OUT = 5;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_mode = 2'd0;
    logic [AW_IN-1:0]  cfg_base = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW_IN-1:0]  in_addr = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [AW_OUT-1:0] out_addr;
    logic              out_oor;
    logic              oor_clr = 1'b0;
    logic [CNT_W-1:0]  oor_count;

    addr_compress_unit #(.AW_IN(AW_IN), .AW_OUT(AW_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_oor(out_oor),
        .oor_clr(oor_clr), .oor_count(oor_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [AW_OUT:0] exp_q[$];
    int m_mode = 0;
    int m_base = 0;
    int m_cnt = 0;
    bit rand_ready = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference mapping from plain integer arithmetic; returns {oor, addr}.
    function automatic logic [AW_OUT:0] ref_map(input int mode, input int base, input int a);
        int span;
        int d;
        int lo;
        int oor;
        int r;
        span = 1 << AW_OUT;
        lo = 0;
        oor = 0;
        case (mode)
            0: lo = a % span;
            1: begin lo = a % span; oor = (a >= span) ? 1 : 0; end
            2: begin
                d = a - base;
                oor = (d < 0 || d >= span) ? 1 : 0;
                lo = (d + (1 << AW_IN)) % span;
            end
            default: begin
                r = a;
                while (r > 0) begin
                    lo = lo ^ (r % span);
                    r = r / span;
                end
            end
        endcase
        return {oor[0], lo[AW_OUT-1:0]};
    endfunction

    // Output monitor: pops the scoreboard on every output transfer and tracks the counter.
    logic held_v = 1'b0;
    logic [AW_OUT:0] held = '0;
    always @(negedge clk) begin
        logic [AW_OUT:0] e;
        bit inc;
        if (!rst_n) begin
            m_cnt = 0;
            held_v = 1'b0;
        end else begin
            inc = 0;
            check("oor_count", oor_count, m_cnt);
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (held_v) begin
                check("held_valid", out_valid, 1);
                check("held_data", {out_oor, out_addr}, held);
            end
            held_v = out_valid && !out_ready;
            held = {out_oor, out_addr};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {out_oor, out_addr}, e);
                    inc = e[AW_OUT];
                end
            end
            if (oor_clr) m_cnt = 0;
            else if (inc && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    // Random backpressure, active only during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic step(input bit v, input int a, input bit cw, input int cm, input int cb,
                        output bit acc);
        in_valid = v;
        in_addr  = a[AW_IN-1:0];
        cfg_we   = cw;
        cfg_mode = cm[1:0];
        cfg_base = cb[AW_IN-1:0];
        @(negedge clk);
        acc = v && in_ready;
        if (acc) exp_q.push_back(ref_map(m_mode, m_base, a));
        @(posedge clk);
        if (cw) begin
            m_mode = cm;
            m_base = cb;
        end
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int a);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1, a, 0, 0, 0, acc);
            tries++;
        end while (!acc && tries < 200);
        check("accept", acc, 1);
    endtask

    task automatic cfg(input int m, input int b);
        bit acc;
        step(0, 0, 1, m, b, acc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int c0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_oor", out_oor, 0);
        check("rst_oor_count", oor_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Truncate, one-cycle latency
        send('hB7);
        @(negedge clk);
        check("lat1_valid", out_valid, 1);
        check("lat1_addr", out_addr, 'h17);
        @(posedge clk); #1;

        cfg(1, 0);
        send('h1F);
        send('h20);
        drain();
        check("check_cnt", oor_count, 1);

        cfg(2, 'h40);
        send('h45);
        send('h5F);
        send('h60);
        send('h3F);
        drain();
        check("offset_cnt_sat", oor_count, 3);

        cfg(3, 0);
        send('hFF);
        send('hA5);
        drain();

        // Backpressure: held beat stays put, second beat waits
        out_ready = 1'b0;
        send('h11);
        in_valid = 1'b1;
        in_addr = 'h22;
        repeat (2) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send('h22);
        drain();

        cfg(0, 0);
        c0 = cyc;
        for (int i = 0; i < 16; i++) send((i * 37 + 11) % 256);
        check("stream_cycles", cyc - c0, 16);
        drain();

        oor_clr = 1'b1;
        @(posedge clk); #1;
        oor_clr = 1'b0;
        check("clr_cnt", oor_count, 0);
        cfg(1, 0);
        for (int i = 0; i < 5; i++) send('h80 + i * 9);
        drain();
        check("cnt2_sat", oor_count, 3);

        // Clear coinciding with an OOR output transfer
        send('hE0);
        oor_clr = 1'b1;
        @(posedge clk); #1;
        oor_clr = 1'b0;
        check("clr_priority", oor_count, 0);
        drain();

        // Config write in the same cycle as an accepted beat
        cfg(0, 0);
        step(1, 'hB7, 1, 2, 'h40, acc);
        check("cfg_same_cycle_accept", acc, 1);
        send('h45);
        drain();

        // Reset while stalled
        out_ready = 1'b0;
        send('h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_midstall_valid", out_valid, 0);
        exp_q.delete();
        m_mode = 0;
        m_base = 0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send('hB7);
        drain();

        // Randomized stream with random config writes, clears and backpressure
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            oor_clr = ($urandom_range(0, 15) == 0);
            if (r == 0) step(1, $urandom_range(0, 255), 1, $urandom_range(0, 3),
                             $urandom_range(0, 255), acc);
            else if (r == 1) step(0, 0, 0, 0, 0, acc);
            else send($urandom_range(0, 255));
            oor_clr = 1'b0;
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
